// File: rtl/pix_sched_pkg.sv
// Shared definitions for the line-burst pixel scheduler.
package pix_sched_pkg;

  localparam int RGB_W_DEF  = 15;
  localparam int LINE_W_DEF = 640;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XFER  = 2'd2
  } state_e;

endpackage

// File: rtl/pix_line_sched_if.sv
// Requester / scanline-buffer signal bundle for pix_line_sched.
interface pix_line_sched_if
  import pix_sched_pkg::*;
#(
  parameter int RGB_W = RGB_W_DEF
);
  logic [1:0]       iREQ;
  logic [1:0]       oGNT;
  logic [RGB_W-1:0] iRGB0;
  logic [RGB_W-1:0] iRGB1;
  logic [1:0]       iVALID;
  logic [1:0]       oREADY;
  logic [1:0]       oDONE;
  logic [RGB_W-1:0] oPIX_RGB;
  logic             oPIX_WRITE;
  logic             oPIX_START;
  logic             iPIX_FULL;
  logic             oBUSY;
  logic [15:0]      oLINES;

  // Scheduler side
  modport slave (
    input  iREQ, iRGB0, iRGB1, iVALID, iPIX_FULL,
    output oGNT, oREADY, oDONE, oPIX_RGB, oPIX_WRITE, oPIX_START, oBUSY, oLINES
  );

  // Requesters plus scanline buffer side
  modport master (
    output iREQ, iRGB0, iRGB1, iVALID, iPIX_FULL,
    input  oGNT, oREADY, oDONE, oPIX_RGB, oPIX_WRITE, oPIX_START, oBUSY, oLINES
  );
endinterface

// File: rtl/pix_line_sched_rr_arb2.sv
// Two-way round-robin arbiter: the last-granted requester loses ties.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd_en,
  output logic [1:0] gnt
);
  // last_q = index of the most recently granted requester
  logic last_q, last_d;

  // Grant selection and pointer advance
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
    if (upd_en && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // Pointer register; reset as if requester 1 went last so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/pix_line_sched.sv
// Arbitrates two requesters for whole-line pixel bursts into a scanline buffer.
module pix_line_sched
  import pix_sched_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int RGB_W  = RGB_W_DEF
) (
  input  logic              iCLK,
  input  logic              iRESETn,
  pix_line_sched_if.slave   bus
);
  localparam int              CNT_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_W - 1);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lines_q, lines_d;
  logic             pix_write_q, pix_write_d;
  logic [RGB_W-1:0] pix_rgb_q, pix_rgb_d;

  logic [1:0]       arb_gnt;
  logic             arb_upd;
  logic [1:0]       ready;
  logic [1:0]       done;
  logic             start;
  logic             xfer;
  logic [RGB_W-1:0] sel_rgb;

  rr_arb2 u_arb (
    .clk    (iCLK),
    .rst_n  (iRESETn),
    .req    (bus.iREQ),
    .upd_en (arb_upd),
    .gnt    (arb_gnt)
  );

  // Next-state, handshake and counter logic for the IDLE/START/XFER sequence
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    arb_upd = 1'b0;
    ready   = 2'b00;
    done    = 2'b00;
    start   = 1'b0;
    xfer    = 1'b0;
    sel_rgb = gnt_q[1] ? bus.iRGB1 : bus.iRGB0;
    case (state_q)
      ST_IDLE: begin
        if (bus.iREQ != 2'b00) begin
          gnt_d   = arb_gnt;
          arb_upd = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        start   = 1'b1;
        state_d = ST_XFER;
      end
      ST_XFER: begin
        ready = gnt_q & {2{~bus.iPIX_FULL}};
        xfer  = |(bus.iVALID & ready);
        if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            done    = gnt_q;
            cnt_d   = '0;
            gnt_d   = 2'b00;
            lines_d = lines_q + 16'd1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
        cnt_d   = '0;
      end
    endcase
    // Accepted pixel is forwarded one cycle later; data holds between writes
    pix_write_d = xfer;
    pix_rgb_d   = xfer ? sel_rgb : pix_rgb_q;
  end

  // State and datapath registers; reset abandons any partial line
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      cnt_q       <= '0;
      lines_q     <= 16'd0;
      pix_write_q <= 1'b0;
      pix_rgb_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      lines_q     <= lines_d;
      pix_write_q <= pix_write_d;
      pix_rgb_q   <= pix_rgb_d;
    end
  end

  assign bus.oGNT       = gnt_q;
  assign bus.oREADY     = ready;
  assign bus.oDONE      = done;
  assign bus.oPIX_START = start;
  assign bus.oPIX_WRITE = pix_write_q;
  assign bus.oPIX_RGB   = pix_rgb_q;
  assign bus.oBUSY      = (state_q != ST_IDLE);
  assign bus.oLINES     = lines_q;
endmodule

// File: tb/tb_pix_line_sched.sv
// Directed bench for pix_line_sched with LINE_W = 4.
module tb_pix_line_sched;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pix_line_sched_if #(.RGB_W(15)) bus ();

  pix_line_sched #(.LINE_W(4), .RGB_W(15)) dut (
    .iCLK    (clk),
    .iRESETn (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  valid;
    logic [14:0] rgb0;
    logic        full;
    logic [1:0]  gnt;
    logic [1:0]  rdy;
    logic [1:0]  done;
    logic        start;
    logic        wr;
    logic [14:0] rgb;
    logic        busy;
    logic [15:0] lines;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic [1:0] req, logic [1:0] valid, logic [14:0] rgb0, logic full,
                              logic [1:0] gnt, logic [1:0] rdy, logic [1:0] done, logic start,
                              logic wr, logic [14:0] rgb, logic busy, logic [15:0] lines);
    vec_t v;
    v.req = req; v.valid = valid; v.rgb0 = rgb0; v.full = full;
    v.gnt = gnt; v.rdy = rdy; v.done = done; v.start = start;
    v.wr = wr; v.rgb = rgb; v.busy = busy; v.lines = lines;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One burst from requester 0: data base+0..3, optional valid gaps and early iREQ drop
  task automatic run_burst(input logic [14:0] base, input bit gaps, input bit drop_req,
                           output int n_start, output int n_wr, output int n_bad,
                           output int n_done, output bit timeout);
    int sent;
    bit fin;
    n_start = 0; n_wr = 0; n_bad = 0; n_done = 0; timeout = 1'b1;
    sent = 0; fin = 1'b0;
    bus.iREQ = 2'b01;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (drop_req && bus.oBUSY) bus.iREQ = 2'b00;
      bus.iRGB0  = base + 15'(sent);
      bus.iVALID = {1'b0, !(gaps && (c % 3 == 1))};
      #1;
      if (bus.oPIX_START) n_start++;
      if (bus.oPIX_WRITE) begin
        if (bus.oPIX_RGB !== base + 15'(n_wr)) n_bad++;
        n_wr++;
      end
      if (bus.oREADY[0] && bus.iVALID[0]) sent++;
      if (fin) begin
        timeout = 1'b0;
        break;
      end
      if (bus.oDONE != 2'b00) begin
        n_done++;
        if (bus.oDONE != 2'b01) n_bad++;
        bus.iREQ = 2'b00;
        fin = 1'b1;
      end
    end
    bus.iVALID = 2'b00;
    bus.iREQ   = 2'b00;
  endtask

  initial begin
    int ns, nw, nb, nd, ngr, nwr, nbad, ndone;
    bit to;
    logic [1:0] gq[4];
    logic [1:0] cur;
    logic [1:0] exp_g[4];

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.iREQ = 2'b00; bus.iVALID = 2'b00; bus.iRGB0 = '0; bus.iRGB1 = '0; bus.iPIX_FULL = 1'b0;

    // Table: single-requester burst, then a burst with 5 cycles of buffer-full
    tbl[0]  = mk(2'b01, 2'b00, 15'h00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 15'h00, 1'b0, 16'd0);
    tbl[1]  = mk(2'b01, 2'b01, 15'h01, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 15'h00, 1'b1, 16'd0);
    tbl[2]  = mk(2'b01, 2'b01, 15'h01, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 15'h00, 1'b1, 16'd0);
    tbl[3]  = mk(2'b01, 2'b01, 15'h02, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 15'h01, 1'b1, 16'd0);
    tbl[4]  = mk(2'b01, 2'b01, 15'h03, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 15'h02, 1'b1, 16'd0);
    tbl[5]  = mk(2'b01, 2'b01, 15'h04, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 15'h03, 1'b1, 16'd0);
    tbl[6]  = mk(2'b00, 2'b00, 15'h00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 15'h04, 1'b0, 16'd1);
    tbl[7]  = mk(2'b00, 2'b00, 15'h00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 15'h00, 1'b0, 16'd1);
    tbl[8]  = mk(2'b01, 2'b01, 15'h11, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 15'h00, 1'b0, 16'd1);
    tbl[9]  = mk(2'b01, 2'b01, 15'h11, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 15'h00, 1'b1, 16'd1);
    tbl[10] = mk(2'b01, 2'b01, 15'h11, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 15'h00, 1'b1, 16'd1);
    tbl[11] = mk(2'b01, 2'b01, 15'h12, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b1, 15'h11, 1'b1, 16'd1);
    tbl[12] = mk(2'b01, 2'b01, 15'h12, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 15'h00, 1'b1, 16'd1);
    tbl[13] = mk(2'b01, 2'b01, 15'h12, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 15'h00, 1'b1, 16'd1);
    tbl[14] = mk(2'b01, 2'b01, 15'h12, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 15'h00, 1'b1, 16'd1);
    tbl[15] = mk(2'b01, 2'b01, 15'h12, 1'b1, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 15'h00, 1'b1, 16'd1);
    tbl[16] = mk(2'b01, 2'b01, 15'h12, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 15'h00, 1'b1, 16'd1);
    tbl[17] = mk(2'b01, 2'b01, 15'h13, 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b1, 15'h12, 1'b1, 16'd1);
    tbl[18] = mk(2'b01, 2'b01, 15'h14, 1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 15'h13, 1'b1, 16'd1);
    tbl[19] = mk(2'b00, 2'b00, 15'h00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 15'h14, 1'b0, 16'd2);

    // Reset state while reset is held
    #3;
    chk("rst gnt",   16'(bus.oGNT), 16'd0);
    chk("rst ready", 16'(bus.oREADY), 16'd0);
    chk("rst done",  16'(bus.oDONE), 16'd0);
    chk("rst write", 16'(bus.oPIX_WRITE), 16'd0);
    chk("rst start", 16'(bus.oPIX_START), 16'd0);
    chk("rst busy",  16'(bus.oBUSY), 16'd0);
    chk("rst rgb",   16'(bus.oPIX_RGB), 16'd0);
    chk("rst lines", bus.oLINES, 16'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.iREQ = tbl[i].req; bus.iVALID = tbl[i].valid;
      bus.iRGB0 = tbl[i].rgb0; bus.iPIX_FULL = tbl[i].full;
      #1;
      chk($sformatf("v%0d gnt", i),   16'(bus.oGNT),       16'(tbl[i].gnt));
      chk($sformatf("v%0d ready", i), 16'(bus.oREADY),     16'(tbl[i].rdy));
      chk($sformatf("v%0d done", i),  16'(bus.oDONE),      16'(tbl[i].done));
      chk($sformatf("v%0d start", i), 16'(bus.oPIX_START), 16'(tbl[i].start));
      chk($sformatf("v%0d write", i), 16'(bus.oPIX_WRITE), 16'(tbl[i].wr));
      if (tbl[i].wr) chk($sformatf("v%0d rgb", i), 16'(bus.oPIX_RGB), 16'(tbl[i].rgb));
      chk($sformatf("v%0d busy", i),  16'(bus.oBUSY),      16'(tbl[i].busy));
      chk($sformatf("v%0d lines", i), bus.oLINES,          tbl[i].lines);
      $display("vec %0d: gnt=%b rdy=%b done=%b start=%b wr=%b rgb=%h lines=%0d",
               i, bus.oGNT, bus.oREADY, bus.oDONE, bus.oPIX_START, bus.oPIX_WRITE, bus.oPIX_RGB, bus.oLINES);
    end

    // Contention: both requesting from reset, grants must alternate starting with requester 0
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    bus.iREQ = 2'b11; bus.iVALID = 2'b11; bus.iRGB0 = 15'h0A; bus.iRGB1 = 15'h0B; bus.iPIX_FULL = 1'b0;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    ngr = 0; nwr = 0; nbad = 0; ndone = 0; cur = 2'b00;
    for (int c = 0; c < 200 && ndone < 4; c++) begin
      @(negedge clk); #1;
      if (bus.oPIX_START) begin
        if (ngr < 4) gq[ngr] = bus.oGNT;
        ngr++;
        cur = bus.oGNT;
      end
      if (bus.oPIX_WRITE) begin
        if (bus.oPIX_RGB !== ((cur == 2'b01) ? 15'h0A : 15'h0B)) nbad++;
        nwr++;
      end
      if (bus.oDONE != 2'b00) begin
        ndone++;
        if (ndone == 4) bus.iREQ = 2'b00;
      end
    end
    @(negedge clk); #1;
    if (bus.oPIX_WRITE) nwr++;
    bus.iVALID = 2'b00; bus.iREQ = 2'b00;
    chk("cont bursts", 16'(ndone), 16'd4);
    chk("cont starts", 16'(ngr), 16'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ngr) chk($sformatf("cont grant%0d", k), 16'(gq[k]), 16'(exp_g[k]));
      $display("contention burst %0d: gnt=%b", k, (k < ngr) ? gq[k] : 2'bxx);
    end
    chk("cont writes", 16'(nwr), 16'd16);
    chk("cont data", 16'(nbad), 16'd0);
    chk("cont lines", bus.oLINES, 16'd4);

    // Reset after two accepted pixels: everything clears asynchronously
    @(negedge clk); bus.iREQ = 2'b01; bus.iVALID = 2'b01; bus.iRGB0 = 15'h21;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); bus.iRGB0 = 15'h22;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid gnt",   16'(bus.oGNT), 16'd0);
    chk("mid ready", 16'(bus.oREADY), 16'd0);
    chk("mid done",  16'(bus.oDONE), 16'd0);
    chk("mid write", 16'(bus.oPIX_WRITE), 16'd0);
    chk("mid start", 16'(bus.oPIX_START), 16'd0);
    chk("mid busy",  16'(bus.oBUSY), 16'd0);
    chk("mid rgb",   16'(bus.oPIX_RGB), 16'd0);
    chk("mid lines", bus.oLINES, 16'd0);
    $display("mid-burst reset: gnt=%b busy=%b lines=%0d", bus.oGNT, bus.oBUSY, bus.oLINES);
    bus.iREQ = 2'b00; bus.iVALID = 2'b00;
    @(negedge clk); rst_n = 1'b1;
    run_burst(15'h31, 1'b0, 1'b0, ns, nw, nb, nd, to);
    $display("post-reset burst: starts=%0d writes=%0d bad=%0d done=%0d timeout=%0d", ns, nw, nb, nd, to);
    chk("rec timeout", 16'(to), 16'd0);
    chk("rec starts", 16'(ns), 16'd1);
    chk("rec writes", 16'(nw), 16'd4);
    chk("rec data",   16'(nb), 16'd0);
    chk("rec lines",  bus.oLINES, 16'd1);

    // iREQ dropped after grant and iVALID gapped
    run_burst(15'h41, 1'b1, 1'b1, ns, nw, nb, nd, to);
    $display("gapped burst: starts=%0d writes=%0d bad=%0d done=%0d timeout=%0d", ns, nw, nb, nd, to);
    chk("gap timeout", 16'(to), 16'd0);
    chk("gap starts", 16'(ns), 16'd1);
    chk("gap writes", 16'(nw), 16'd4);
    chk("gap data",   16'(nb), 16'd0);
    chk("gap done",   16'(nd), 16'd1);
    chk("gap idle",   16'(bus.oBUSY), 16'd0);

    // Line counter wrap from 0xFFFF
    @(negedge clk);
    force dut.lines_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.lines_q;
    @(negedge clk); #1;
    chk("wrap preload", bus.oLINES, 16'hFFFF);
    run_burst(15'h51, 1'b0, 1'b0, ns, nw, nb, nd, to);
    $display("wrap burst: writes=%0d lines=%h", nw, bus.oLINES);
    chk("wrap writes", 16'(nw), 16'd4);
    chk("wrap lines",  bus.oLINES, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pix_line_sched.md
PIX_LINE_SCHED -- requirements
Module: pix_line_sched

Interface
REQ-001 Parameter LINE_W, default 640, pixels per line burst (legal range 2..4096).
REQ-002 Parameter RGB_W, default 15, pixel width (5:5:5 RGB).
REQ-003 iCLK  in  1  sole clock, memory/pixel-write clock domain; all logic on its rising edge.
REQ-004 iRESETn  in  1  asynchronous active-low reset.
REQ-005 iREQ  in  2  per-requester line-burst request, level, bit n = requester n.
REQ-006 oGNT  out  2  one-hot grant, held for the whole burst.
REQ-007 iRGB0 / iRGB1  in  RGB_W each  requester pixel data.
REQ-008 iVALID  in  2  per-requester pixel valid.
REQ-009 oREADY  out  2  per-requester pixel ready.
REQ-010 oDONE  out  2  one-cycle pulse when the last pixel of that requester's burst is accepted.
REQ-011 oPIX_RGB  out  RGB_W  pixel to scanline buffer.
REQ-012 oPIX_WRITE  out  1  pixel write strobe.
REQ-013 oPIX_START  out  1  line-start strobe to scanline buffer.
REQ-014 iPIX_FULL  in  1  scanline buffer full.
REQ-015 oBUSY  out  1  high in any state other than IDLE.
REQ-016 oLINES  out  16  count of completed bursts.

Function
REQ-017 FSM states: IDLE, START, XFER.
REQ-018 IDLE: with iREQ != 0, grant per round-robin, register oGNT, and go to START; otherwise stay.
REQ-019 Round-robin: the last-granted requester has lowest priority; after reset requester 0 has priority.
REQ-020 START: oPIX_START = 1 for exactly one cycle, no pixel write; next state XFER.
REQ-021 XFER: oREADY[g] = !iPIX_FULL (combinational) for the granted g; ungranted oREADY = 0.
REQ-022 Transfer = iVALID[g] & oREADY[g].
REQ-023 On transfer, oPIX_WRITE and oPIX_RGB are registered: 1-cycle latency, exactly one write per transfer, pixel order preserved.
REQ-024 Pixel counter width = clog2(LINE_W); increments per transfer.
REQ-025 Transfer at count LINE_W-1: oDONE[g] pulses that cycle, counter clears, oGNT clears, oLINES += 1, state returns to IDLE.
REQ-026 Back-to-back bursts are separated by a minimum of 1 IDLE cycle, giving START-to-START ≥ LINE_W+2 cycles.
REQ-027 iREQ deassertion during START/XFER is ignored; the burst completes all LINE_W pixels.
REQ-028 iVALID gaps stall XFER indefinitely with no write and no timeout.
REQ-029 iPIX_FULL high blocks transfers; because of the registered write, one accepted pixel can land after full rises.
REQ-030 The scanline buffer provides at least 1 entry of slack beyond its full threshold.
REQ-031 oLINES wraps 0xFFFF -> 0x0000.
REQ-032 Simultaneous iREQ = 2'b11 in IDLE: exactly one grant per round-robin, and the other requester is served next.

Reset
REQ-033 On iRESETn low, asynchronously:
- state = IDLE;
- oGNT, oREADY, oDONE, oPIX_WRITE, oPIX_START, oBUSY = 0;
- oPIX_RGB = 0, oLINES = 0, counter = 0;
- round-robin pointer = requester 0 priority.
REQ-034 Reset mid-burst abandons the partial line; no further pix strobes occur until a new grant.

Structure
REQ-035 Shared package pix_sched_pkg holds the FSM state enum, RGB_W default and LINE_W default.
REQ-036 One sub-module, rr_arb2: 2-way round-robin arbiter with request, pointer-update enable and one-hot grant.

Verification (bench LINE_W=4)
REQ-037 Single requester: iREQ=01, iVALID0 constant, RGB 0x0001..0x0004 -> oGNT=01, oPIX_START one pulse, four oPIX_WRITE with 0x0001..0x0004 each 1 cycle after acceptance, oDONE=01 on the 4th, oLINES=1.
REQ-038 Contention: iREQ=11 held from reset -> grants 01,10,01,10; oLINES=4 after 4 bursts.
REQ-039 Backpressure: iPIX_FULL high for 5 cycles mid-burst -> oREADY0=0 during those cycles, no extra writes, total writes exactly 4, order preserved.
REQ-040 Reset mid-XFER after 2 pixels -> all outputs 0 asynchronously, oLINES=0; next request yields fresh START and 4 writes.
REQ-041 Wrap: preload 0xFFFF bursts (or force) -> next oDONE makes oLINES=0x0000.
REQ-042 iREQ dropped after grant and iVALID gapped -> burst still completes with 4 writes, no new START before oDONE.
